// File: rtl/neko_axilite_slice.sv
// Registered AXI4-Lite slice: one 2-entry skid buffer per channel, fixed AxPROT.
// Optional response watchdog is compiled in when NEKO_AXILITE_TIMEOUT_EN is defined.

module neko_axilite_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  output logic [W-1:0] out_data_o,
  output logic         out_valid_o,
  input  logic         out_ready_i
);
  logic [W-1:0] main_q, main_d, skid_q, skid_d;
  logic         main_full_q, main_full_d, skid_full_q, skid_full_d;
  logic         ready_q;
  logic         in_fire;

  assign in_fire = in_valid_i & ready_q;

  always_comb begin
    // NOTE: every always_comb target gets a default first so no latch is inferred.
    main_d      = main_q;
    skid_d      = skid_q;
    main_full_d = main_full_q;
    skid_full_d = skid_full_q;
    if (!skid_full_q) begin
      if (!main_full_q || out_ready_i) begin
        main_full_d = in_fire;
        if (in_fire) main_d = in_data_i;
      end else if (in_fire) begin
        skid_d      = in_data_i;
        skid_full_d = 1'b1;
      end
    end else if (out_ready_i) begin
      // Skid only fills while main is full, so main stays full here.
      main_d      = skid_q;
      skid_full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      // NOTE: payload registers are reset too, so no stale data is ever visible.
      main_q      <= '0;
      skid_q      <= '0;
      main_full_q <= 1'b0;
      skid_full_q <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      main_q      <= main_d;
      skid_q      <= skid_d;
      main_full_q <= main_full_d;
      skid_full_q <= skid_full_d;
      ready_q     <= !skid_full_d;
    end
  end

  assign in_ready_o  = ready_q;
  assign out_valid_o = main_full_q;
  assign out_data_o  = main_q;
endmodule

`ifdef NEKO_AXILITE_TIMEOUT_EN
module neko_axilite_wdog #(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic issue_i,
  input  logic rsp_valid_i,
  input  logic buf_ready_i,
  output logic hold_o,
  output logic inject_o,
  output logic stale_o
);
  localparam logic [15:0] LAST = 16'(LIMIT - 1);

  logic        out_q, stale_q;
  logic [15:0] cnt_q;
  logic        rsp_hs, at_limit;

  // A real response in the limit cycle clears the request and suppresses injection.
  assign rsp_hs   = out_q & rsp_valid_i & buf_ready_i;
  assign at_limit = out_q & (cnt_q == LAST);
  assign inject_o = at_limit & ~rsp_hs & buf_ready_i;
  assign hold_o   = out_q | stale_q;
  assign stale_o  = stale_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q   <= 1'b0;
      stale_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      if (issue_i) begin
        out_q <= 1'b1;
        cnt_q <= '0;
      end else if (rsp_hs || inject_o) begin
        out_q <= 1'b0;
      end else if (out_q && !at_limit) begin
        cnt_q <= cnt_q + 16'd1;
      end
      if (inject_o) stale_q <= 1'b1;
      else if (stale_q && rsp_valid_i) stale_q <= 1'b0;
    end
  end
endmodule
`endif

module neko_axilite_slice #(
  parameter int ADDR_WIDTH     = 11,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [2:0]              m_axi_awprot,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [2:0]              m_axi_arprot,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
);
  localparam int SW = DATA_WIDTH / 8;

  if (!(DATA_WIDTH == 32 || DATA_WIDTH == 64)) begin : g_bad_dw
    $error("neko_axilite_slice: DATA_WIDTH must be 32 or 64");
  end
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_to
    $error("neko_axilite_slice: TIMEOUT_CYCLES must be 2..65535");
  end

  logic                  aw_valid, ar_valid, aw_hold, ar_hold;
  logic                  b_in_valid, b_in_ready, r_in_valid, r_in_ready;
  logic [1:0]            b_in_resp;
  logic [DATA_WIDTH+1:0] r_in_data;

`ifdef NEKO_AXILITE_TIMEOUT_EN
  logic b_inject, b_stale, r_inject, r_stale;

  neko_axilite_wdog #(.LIMIT(TIMEOUT_CYCLES)) u_wr_wdog (
    .clk, .rst,
    .issue_i     (m_axi_awvalid & m_axi_awready),
    .rsp_valid_i (m_axi_bvalid),
    .buf_ready_i (b_in_ready),
    .hold_o      (aw_hold),
    .inject_o    (b_inject),
    .stale_o     (b_stale)
  );
  neko_axilite_wdog #(.LIMIT(TIMEOUT_CYCLES)) u_rd_wdog (
    .clk, .rst,
    .issue_i     (m_axi_arvalid & m_axi_arready),
    .rsp_valid_i (m_axi_rvalid),
    .buf_ready_i (r_in_ready),
    .hold_o      (ar_hold),
    .inject_o    (r_inject),
    .stale_o     (r_stale)
  );

  // A stale direction swallows the late downstream response instead of forwarding it.
  assign b_in_valid   = b_inject | (m_axi_bvalid & ~b_stale);
  assign b_in_resp    = b_inject ? 2'b10 : m_axi_bresp;
  assign m_axi_bready = b_stale | b_in_ready;
  assign r_in_valid   = r_inject | (m_axi_rvalid & ~r_stale);
  assign r_in_data    = r_inject ? {2'b10, {DATA_WIDTH{1'b1}}} : {m_axi_rresp, m_axi_rdata};
  assign m_axi_rready = r_stale | r_in_ready;
`else
  assign aw_hold      = 1'b0;
  assign ar_hold      = 1'b0;
  assign b_in_valid   = m_axi_bvalid;
  assign b_in_resp    = m_axi_bresp;
  assign m_axi_bready = b_in_ready;
  assign r_in_valid   = m_axi_rvalid;
  assign r_in_data    = {m_axi_rresp, m_axi_rdata};
  assign m_axi_rready = r_in_ready;
`endif

  assign m_axi_awprot  = 3'b000;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_awvalid = aw_valid & ~aw_hold;
  assign m_axi_arvalid = ar_valid & ~ar_hold;

  neko_axilite_skid #(.W(ADDR_WIDTH)) u_aw (
    .clk, .rst,
    .in_data_i (s_axi_awaddr), .in_valid_i (s_axi_awvalid), .in_ready_o (s_axi_awready),
    .out_data_o (m_axi_awaddr), .out_valid_o (aw_valid), .out_ready_i (m_axi_awready & ~aw_hold)
  );
  neko_axilite_skid #(.W(DATA_WIDTH + SW)) u_w (
    .clk, .rst,
    .in_data_i ({s_axi_wstrb, s_axi_wdata}), .in_valid_i (s_axi_wvalid), .in_ready_o (s_axi_wready),
    .out_data_o ({m_axi_wstrb, m_axi_wdata}), .out_valid_o (m_axi_wvalid), .out_ready_i (m_axi_wready)
  );
  neko_axilite_skid #(.W(ADDR_WIDTH)) u_ar (
    .clk, .rst,
    .in_data_i (s_axi_araddr), .in_valid_i (s_axi_arvalid), .in_ready_o (s_axi_arready),
    .out_data_o (m_axi_araddr), .out_valid_o (ar_valid), .out_ready_i (m_axi_arready & ~ar_hold)
  );
  neko_axilite_skid #(.W(2)) u_b (
    .clk, .rst,
    .in_data_i (b_in_resp), .in_valid_i (b_in_valid), .in_ready_o (b_in_ready),
    .out_data_o (s_axi_bresp), .out_valid_o (s_axi_bvalid), .out_ready_i (s_axi_bready)
  );
  neko_axilite_skid #(.W(DATA_WIDTH + 2)) u_r (
    .clk, .rst,
    .in_data_i (r_in_data), .in_valid_i (r_in_valid), .in_ready_o (r_in_ready),
    .out_data_o ({s_axi_rresp, s_axi_rdata}), .out_valid_o (s_axi_rvalid), .out_ready_i (s_axi_rready)
  );
endmodule

// File: tb/tb_neko_axilite_slice.sv
// Self-checking bench for neko_axilite_slice: directed cases plus random traffic
// checked against per-channel FIFO ordering, stability and timeout expectations.

module tb_neko_axilite_slice;
  localparam int AW = 11;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] s_axi_awaddr, s_axi_araddr, m_axi_awaddr, m_axi_araddr;
  logic          s_axi_awvalid, s_axi_awready, s_axi_arvalid, s_axi_arready;
  logic [DW-1:0] s_axi_wdata, m_axi_wdata, s_axi_rdata, m_axi_rdata;
  logic [SW-1:0] s_axi_wstrb, m_axi_wstrb;
  logic          s_axi_wvalid, s_axi_wready, m_axi_wvalid, m_axi_wready;
  logic [1:0]    s_axi_bresp, m_axi_bresp, s_axi_rresp, m_axi_rresp;
  logic          s_axi_bvalid, s_axi_bready, m_axi_bvalid, m_axi_bready;
  logic          s_axi_rvalid, s_axi_rready, m_axi_rvalid, m_axi_rready;
  logic [2:0]    m_axi_awprot, m_axi_arprot;
  logic          m_axi_awvalid, m_axi_awready, m_axi_arvalid, m_axi_arready;

  int n_errors = 0;
  int n_checks = 0;
  int r_out_cnt = 0;
  bit swallow_r = 1'b0;

  always #5 clk = ~clk;

  neko_axilite_slice #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Channel views: 0 AW, 1 W, 2 AR, 3 B, 4 R.
  logic [4:0]  in_v, in_r, out_v, out_r;
  logic [63:0] in_d[5];
  logic [63:0] out_d[5];

  assign in_v  = {m_axi_rvalid, m_axi_bvalid, s_axi_arvalid, s_axi_wvalid, s_axi_awvalid};
  assign in_r  = {m_axi_rready, m_axi_bready, s_axi_arready, s_axi_wready, s_axi_awready};
  assign out_v = {s_axi_rvalid, s_axi_bvalid, m_axi_arvalid, m_axi_wvalid, m_axi_awvalid};
  assign out_r = {s_axi_rready, s_axi_bready, m_axi_arready, m_axi_wready, m_axi_awready};
  assign in_d[0]  = 64'(s_axi_awaddr);
  assign in_d[1]  = 64'({s_axi_wstrb, s_axi_wdata});
  assign in_d[2]  = 64'(s_axi_araddr);
  assign in_d[3]  = 64'(m_axi_bresp);
  assign in_d[4]  = 64'({m_axi_rresp, m_axi_rdata});
  assign out_d[0] = 64'(m_axi_awaddr);
  assign out_d[1] = 64'({m_axi_wstrb, m_axi_wdata});
  assign out_d[2] = 64'(m_axi_araddr);
  assign out_d[3] = 64'(s_axi_bresp);
  assign out_d[4] = 64'({s_axi_rresp, s_axi_rdata});

  // Reference model: each channel is a FIFO of accepted beats; a stalled output must hold.
  logic [63:0] model_q[5][$];
  logic [63:0] held[5];
  bit          stalled[5];

  always @(negedge clk) begin
    if (rst) begin
      for (int c = 0; c < 5; c++) begin
        model_q[c].delete();
        stalled[c] = 1'b0;
      end
    end else begin
      for (int c = 0; c < 5; c++) begin
        if (stalled[c]) begin
          check($sformatf("hold_valid_ch%0d", c), 64'(out_v[c]), 64'd1);
          check($sformatf("hold_data_ch%0d", c), out_d[c], held[c]);
        end
        if (out_v[c] && out_r[c]) begin
          if (c == 4) r_out_cnt++;
          if (model_q[c].size() == 0) check($sformatf("extra_beat_ch%0d", c), out_d[c], 64'hX);
          else check($sformatf("order_ch%0d", c), out_d[c], model_q[c].pop_front());
        end
        if (in_v[c] && in_r[c]) begin
          if (c == 4 && swallow_r) swallow_r = 1'b0;
          else model_q[c].push_back(in_d[c]);
        end
        stalled[c] = out_v[c] && !out_r[c];
        held[c]    = out_d[c];
      end
    end
  end

`ifdef NEKO_AXILITE_TIMEOUT_EN
  localparam bit ADDR_RANDOM = 1'b0;
`else
  localparam bit ADDR_RANDOM = 1'b1;
`endif

  bit f_aw, f_w, f_ar, f_b, f_r;

  task automatic sample_fires();
    f_aw = s_axi_awvalid & s_axi_awready;
    f_w  = s_axi_wvalid & s_axi_wready;
    f_ar = s_axi_arvalid & s_axi_arready;
    f_b  = m_axi_bvalid & m_axi_bready;
    f_r  = m_axi_rvalid & m_axi_rready;
  endtask

  task automatic random_phase(input int cycles);
    f_aw = 0; f_w = 0; f_ar = 0; f_b = 0; f_r = 0;
    for (int cyc = 0; cyc < cycles; cyc++) begin
      if (!s_axi_awvalid || f_aw) begin
        s_axi_awvalid = ADDR_RANDOM && ($urandom_range(0, 3) != 0);
        s_axi_awaddr  = AW'($urandom);
      end
      if (!s_axi_wvalid || f_w) begin
        s_axi_wvalid = ($urandom_range(0, 3) != 0);
        s_axi_wdata  = DW'($urandom);
        s_axi_wstrb  = SW'($urandom);
      end
      if (!s_axi_arvalid || f_ar) begin
        s_axi_arvalid = ADDR_RANDOM && ($urandom_range(0, 3) != 0);
        s_axi_araddr  = AW'($urandom);
      end
      if (!m_axi_bvalid || f_b) begin
        m_axi_bvalid = ($urandom_range(0, 2) == 0);
        m_axi_bresp  = 2'($urandom);
      end
      if (!m_axi_rvalid || f_r) begin
        m_axi_rvalid = ($urandom_range(0, 1) == 0);
        m_axi_rdata  = DW'($urandom);
        m_axi_rresp  = 2'($urandom);
      end
      m_axi_awready = ($urandom_range(0, 2) != 0);
      m_axi_wready  = ($urandom_range(0, 2) != 0);
      m_axi_arready = ($urandom_range(0, 2) != 0);
      s_axi_bready  = ($urandom_range(0, 2) != 0);
      s_axi_rready  = ($urandom_range(0, 2) != 0);
      sample_fires();
      tick();
    end
    // Finish outstanding source beats with every sink ready, then let the pipe empty.
    m_axi_awready = 1; m_axi_wready = 1; m_axi_arready = 1; s_axi_bready = 1; s_axi_rready = 1;
    for (int k = 0; k < 50 && (s_axi_awvalid || s_axi_wvalid || s_axi_arvalid ||
                               m_axi_bvalid || m_axi_rvalid); k++) begin
      sample_fires();
      tick();
      if (f_aw) s_axi_awvalid = 0;
      if (f_w)  s_axi_wvalid  = 0;
      if (f_ar) s_axi_arvalid = 0;
      if (f_b)  m_axi_bvalid  = 0;
      if (f_r)  m_axi_rvalid  = 0;
    end
    check("rand_sources_done",
          64'({s_axi_awvalid, s_axi_wvalid, s_axi_arvalid, m_axi_bvalid, m_axi_rvalid}), 64'd0);
    repeat (6) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int base_cnt;
    int k;
    rst = 1;
    s_axi_awaddr = '0; s_axi_awvalid = 0; s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 0;
    s_axi_bready = 0; s_axi_araddr = '0; s_axi_arvalid = 0; s_axi_rready = 0;
    m_axi_awready = 0; m_axi_wready = 0; m_axi_bresp = '0; m_axi_bvalid = 0;
    m_axi_arready = 0; m_axi_rdata = '0; m_axi_rresp = '0; m_axi_rvalid = 0;

    // Reset release
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rst_valids", 64'(out_v), 64'd0);
      check("rst_readies", 64'(in_r), 64'd0);
    end
    rst = 0;
    tick();
    check("post_rst_readies", 64'(in_r), 64'h1F);
    check("post_rst_valids", 64'(out_v), 64'd0);
    check("prot_zero", 64'({m_axi_awprot, m_axi_arprot}), 64'd0);

`ifndef NEKO_AXILITE_TIMEOUT_EN
    // Streaming AR: one beat per cycle, one cycle of latency
    m_axi_arready = 1;
    for (int i = 0; i < 8; i++) begin
      s_axi_arvalid = 1;
      s_axi_araddr  = AW'(i * 4);
      tick();
      check("stream_arvalid", 64'(m_axi_arvalid), 64'd1);
      check("stream_araddr", 64'(m_axi_araddr), 64'(i * 4));
      check("stream_arready", 64'(s_axi_arready), 64'd1);
    end
    s_axi_arvalid = 0;
    tick();
    check("stream_end", 64'(m_axi_arvalid), 64'd0);
    m_axi_arready = 0;
`endif

    // W backpressure
    m_axi_wready = 0;
    s_axi_wstrb  = '1;
    s_axi_wvalid = 1; s_axi_wdata = 32'hA5A5_0001;
    tick();
    check("bp_ready_after1", 64'(s_axi_wready), 64'd1);
    s_axi_wdata = 32'hA5A5_0002;
    tick();
    check("bp_ready_after2", 64'(s_axi_wready), 64'd0);
    check("bp_head_data", 64'(m_axi_wdata), 64'hA5A5_0001);
    s_axi_wdata = 32'hA5A5_0003;
    tick();
    check("bp_ready_still_low", 64'(s_axi_wready), 64'd0);
    m_axi_wready = 1;
    tick();
    check("bp_exit2", 64'(m_axi_wdata), 64'hA5A5_0002);
    check("bp_ready_back", 64'(s_axi_wready), 64'd1);
    tick();
    s_axi_wvalid = 0;
    check("bp_exit3", 64'(m_axi_wdata), 64'hA5A5_0003);
    tick();
    check("bp_empty", 64'(m_axi_wvalid), 64'd0);

    // R response path under a toggling consumer
    base_cnt = r_out_cnt;
    s_axi_rready = 1;
    m_axi_rvalid = 1; m_axi_rdata = 32'h1234_5678; m_axi_rresp = 2'b00;
    check("resp_m_rready", 64'(m_axi_rready), 64'd1);
    tick();
    m_axi_rvalid = 0;
    s_axi_rready = 0;
    check("resp_valid", 64'(s_axi_rvalid), 64'd1);
    check("resp_data", 64'({s_axi_rresp, s_axi_rdata}), 64'h0_1234_5678);
    tick();
    check("resp_stall_data", 64'(s_axi_rdata), 64'h1234_5678);
    s_axi_rready = 1;
    tick();
    s_axi_rready = 0;
    check("resp_consumed", 64'(s_axi_rvalid), 64'd0);
    tick();
    check("resp_once", 64'(r_out_cnt - base_cnt), 64'd1);

    // Reset while two W beats are buffered
    m_axi_wready = 0;
    s_axi_wvalid = 1; s_axi_wdata = 32'h0000_00B0;
    tick();
    s_axi_wdata = 32'h0000_00B1;
    tick();
    s_axi_wvalid = 0;
    check("midrst_buffered", 64'(m_axi_wvalid), 64'd1);
    rst = 1;
    tick();
    check("midrst_valid_drop", 64'(m_axi_wvalid), 64'd0);
    check("midrst_ready_low", 64'(s_axi_wready), 64'd0);
    rst = 0;
    m_axi_wready = 1;
    tick();
    check("midrst_ready_back", 64'(s_axi_wready), 64'd1);
    repeat (3) tick();
    check("midrst_no_ghost", 64'(m_axi_wvalid), 64'd0);

    // Random traffic on all channels
    random_phase(600);

`ifdef NEKO_AXILITE_TIMEOUT_EN
    // Watchdog: silent slave, injected error, late response swallowed, next AR issued
    m_axi_arready = 1; s_axi_rready = 0; m_axi_rvalid = 0;
    s_axi_arvalid = 1; s_axi_araddr = 11'h040;
    tick();
    s_axi_arvalid = 0;
    check("to_ar_issue", 64'(m_axi_arvalid), 64'd1);
    tick();
    model_q[4].push_back(64'({2'b10, 32'hFFFF_FFFF}));
    k = 41;
    for (int j = 1; j <= 40; j++) begin
      tick();
      if (s_axi_rvalid) begin
        k = j;
        break;
      end
    end
    check("to_latency", 64'(k), 64'(TO));
    check("to_rresp", 64'(s_axi_rresp), 64'd2);
    check("to_rdata", 64'(s_axi_rdata), 64'hFFFF_FFFF);
    check("to_ar_held", 64'(m_axi_arvalid), 64'd0);
    s_axi_rready = 1;
    tick();
    s_axi_rready = 0;
    swallow_r = 1;
    m_axi_rvalid = 1; m_axi_rdata = 32'hDEAD_0000; m_axi_rresp = 2'b00;
    check("to_forced_rready", 64'(m_axi_rready), 64'd1);
    tick();
    m_axi_rvalid = 0;
    repeat (3) tick();
    check("to_swallowed", 64'(s_axi_rvalid), 64'd0);
    s_axi_arvalid = 1; s_axi_araddr = 11'h044;
    tick();
    s_axi_arvalid = 0;
    check("to_next_ar", 64'(m_axi_arvalid), 64'd1);
    check("to_next_addr", 64'(m_axi_araddr), 64'h044);
    tick();
    m_axi_rvalid = 1; m_axi_rdata = 32'h0BAD_F00D; m_axi_rresp = 2'b00;
    tick();
    m_axi_rvalid = 0;
    check("to_next_resp", 64'({s_axi_rvalid, s_axi_rdata}), 64'h1_0BAD_F00D);
    s_axi_rready = 1;
    repeat (3) tick();
`endif

    for (int c = 0; c < 5; c++) check($sformatf("final_drain_ch%0d", c), 64'(model_q[c].size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/neko_axilite_slice.md
Name: neko_axilite_slice

Overview:
- Registered AXI4-Lite pipeline stage between the NoC-to-AXI-Lite bridge (upstream master) and the compute-unit AXI-Lite slave (downstream).
- Breaks every combinational valid/ready path across the five channels using 2-entry skid buffers, and drives the protection signals that the bridge does not produce.
- Sustains one beat per cycle per channel with 1 cycle of forward latency.

Parameters:
- ADDR_WIDTH, 11, AXI-Lite address width on both sides.
- DATA_WIDTH, 32, AXI-Lite data width; must be 32 or 64.
- TIMEOUT_CYCLES, 1024, watchdog limit in cycles; only used when NEKO_AXILITE_TIMEOUT_EN is defined; legal range 2..65535.

Ports:
- clk  in  1  chipset clock
- rst  in  1  synchronous, active-high reset
- s_axi_awaddr/awvalid/awready  in/in/out  ADDR_WIDTH/1/1  upstream write address
- s_axi_wdata/wstrb/wvalid/wready  in/in/in/out  DATA_WIDTH/DATA_WIDTH/8/1/1  upstream write data
- s_axi_bresp/bvalid/bready  out/out/in  2/1/1  upstream write response
- s_axi_araddr/arvalid/arready  in/in/out  ADDR_WIDTH/1/1  upstream read address
- s_axi_rdata/rresp/rvalid/rready  out/out/out/in  DATA_WIDTH/2/1/1  upstream read data
- m_axi_awaddr/awprot/awvalid/awready  out/out/out/in  ADDR_WIDTH/3/1/1  downstream write address
- m_axi_wdata/wstrb/wvalid/wready  out/out/out/in  DATA_WIDTH/DATA_WIDTH/8/1/1  downstream write data
- m_axi_bresp/bvalid/bready  in/in/out  2/1/1  downstream write response
- m_axi_araddr/arprot/arvalid/arready  out/out/out/in  ADDR_WIDTH/3/1/1  downstream read address
- m_axi_rdata/rresp/rvalid/rready  in/in/in/out  DATA_WIDTH/2/1/1  downstream read data

Behaviour:
- Clocking and reset: single clock domain. Reset is synchronous, active-high, sampled on posedge clk.
- Skid buffer, one per channel (AW, W, AR forward; B, R backward):
  - Each buffer has a main register and a skid register.
  - Input ready = registered "skid empty". Output valid = registered "main full".
- Reset values:
  - All *valid outputs = 0.
  - All *ready outputs = 0 while rst is high; they rise to 1 on the first cycle after rst is deasserted.
  - Data registers reset to 0.
  - m_axi_awprot = m_axi_arprot = 3'b000 constant.
- Transfer rules:
  - Input beat accepted when valid && ready.
  - Main empty: beat goes to main, and output valid rises next cycle (latency 1).
  - Main full and output not consumed: beat goes to skid, and ready drops next cycle.
  - Output consumed and skid full: skid moves to main and ready rises next cycle.
  - Simultaneous accept and consume with skid empty: main reloads directly; throughput is 1 beat/cycle.
- Ordering and stability:
  - Beats are never dropped, duplicated or reordered within a channel.
  - Output data is stable while valid is high and ready is low (AXI rule).
  - Once valid is asserted, it is never withdrawn without a handshake.
- Channel independence: channels are independent, with no AW/W pairing logic. The downstream slave handles AW/W skew.
- Reset mid-transfer: all buffered beats are discarded and valids drop in the reset cycle. Upstream must re-issue.

Optional Feature:
- Macro: NEKO_AXILITE_TIMEOUT_EN
- Defined (watchdog enabled):
  - At most 1 outstanding write and 1 outstanding read. AW is held in its buffer (m_axi_awvalid = 0) while a write is outstanding; AR likewise for reads.
  - A write becomes outstanding on the m_axi AW handshake. A read becomes outstanding on the m_axi AR handshake.
  - Per-direction counter starts at 0 and increments each cycle while that direction is outstanding.
  - If the counter reaches TIMEOUT_CYCLES with no downstream response, the slice injects an upstream response into the B/R buffer: BRESP=2'b10, or RRESP=2'b10 with RDATA=all-ones. It then clears outstanding and sets a per-direction stale flag.
  - While stale is set, m_axi_bready (or m_axi_rready) is forced to 1. The next downstream response is swallowed and not forwarded, and that clears stale.
  - New AW/AR is not issued while stale is set.
  - Response arriving in the same cycle as the counter reaching the limit: the real response wins and no error is injected.
- Not defined: no counters, no outstanding limit, pure skid-buffer pipeline.

Test Plan:
- Reset release: hold rst 4 cycles then deassert -> all valids 0 throughout; all s_*ready/m_*ready = 1 on the 1st post-reset cycle; awprot/arprot = 0.
- Streaming: 8 back-to-back AR beats addr 0x000..0x01C with m_arready = 1 -> m_araddr matches in order, 1 cycle delay, 8 consecutive valid cycles.
- Backpressure: m_wready = 0 while 3 W beats (0xA5A5_0001..3) are offered -> 2 accepted, s_wready drops after the 2nd; release m_wready -> beats exit in order 1, 2, 3 with no loss.
- Response path: slave returns RDATA = 0x1234_5678, RRESP = 0 while s_rready toggles 1010 -> same data delivered once, stable while stalled.
- Reset mid-transfer: assert rst with 2 W beats buffered -> m_wvalid = 0 next cycle; no buffered beat appears after reset.
- Timeout (macro on, TIMEOUT_CYCLES = 16): AR to a silent slave -> s_rvalid with RRESP = 2'b10, RDATA = 0xFFFF_FFFF at cycle 16; a late slave R is swallowed; the next AR is then issued normally.
